fb_glyph_writer: RTL and testbench
==================================

# fb_glyph_writer

Write-side engine for the 640x480 1-bpp VGA framebuffer (20 x 32-bit words per line, 9600 words, leftmost pixel in bit 31). It accepts draw commands, streams 16x32 glyph bitmaps into 16-pixel-aligned character cells, and optionally fills the whole framebuffer with a word pattern. Its write port drives the framebuffer RAM's write side; the VGA scan-out block owns the read side.

## Interface
Parameters:
- WORDS_PER_LINE, 20, framebuffer words per scan line
- LINES, 480, scan lines
- GLYPH_ROWS, 32, bitmap rows per glyph
- AW, 14, word-address width

Ports:
- CLK  in  1  system clock; all outputs registered on its rising edge
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0 = glyph, 1 = clear
- cmd_col  in  6  cell column, 0..39 (16-pixel cells)
- cmd_row  in  9  top scan line of the glyph, 0..LINES-GLYPH_ROWS
- cmd_fill  in  32  fill word for clear
- row_valid  in  1  glyph row beat valid
- row_ready  out  1  high only in GLYPH
- row_data  in  16  glyph row; bit 15 is the leftmost pixel
- wr_en  out  1  write strobe, one word per cycle
- wr_addr  out  AW  word address
- wr_data  out  32  write data
- wr_be  out  2  halfword enables: bit1 = [31:16], bit0 = [15:0]
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on the final write of a command
- err  out  1  one-cycle pulse on a rejected command

## Operation
- States: IDLE, GLYPH, CLEAR.
- IDLE: cmd_ready = 1. Handshake (cmd_valid & cmd_ready) latches the command.
  - Validity check: glyph requires cmd_col <= 39 and cmd_row <= LINES-GLYPH_ROWS (448). Clear requires FBW_CLEAR_EN.
  - Invalid command: it is still consumed, err pulses the next cycle, no writes occur, and the block stays in IDLE.
  - Valid glyph: base = cmd_row*WORDS_PER_LINE + cmd_col[5:1]; lane = cmd_col[0]; row counter = 0; go to GLYPH.
  - Valid clear: address counter = 0; go to CLEAR.
- GLYPH: row_ready = 1. Each row handshake issues one write:
  - wr_addr = base + i*WORDS_PER_LINE. The address is accumulated by repeated +20; no multiplier on the per-row path.
  - Even column (lane 0): wr_data = {row_data, 16'h0}, wr_be = 2'b10.
  - Odd column (lane 1): wr_data = {16'h0, row_data}, wr_be = 2'b01.
  - On beat GLYPH_ROWS-1: done pulses with that write, and the state returns to IDLE.
- CLEAR: one write per cycle, no backpressure. wr_addr = 0..LINES*WORDS_PER_LINE-1 (9599), wr_data = cmd_fill, wr_be = 2'b11. done pulses with the address-9599 write, then the state returns to IDLE.
- row_valid outside GLYPH is ignored (row_ready = 0); row_data is never consumed outside GLYPH.
- Address arithmetic is AW bits wide and never exceeds 9599, so no wrap occurs.

## Timing
- Reset (asynchronous) returns the block to IDLE with cmd_ready = 1 and every other output 0: row_ready, wr_en, wr_addr, wr_data, wr_be, busy, done, err.
- Reset mid-command aborts the command. Partially written words remain written.
- Command accepted at edge k: busy = 1 and row_ready = 1 (GLYPH) from edge k.
  - CLEAR: the first write (address 0) is presented from edge k+1. The last write (9599) is at edge k+9600, with done.
- Glyph row handshake at edge n: wr_en, wr_addr, wr_data and wr_be are valid in the cycle after edge n, for one cycle. wr_en = 0 in cycles with no handshake.
- At the edge of the last row handshake: the state changes to IDLE, cmd_ready = 1 and busy = 0 in the same cycle that the final wr_en and done are high. A new command can be accepted on the next edge.
- Throughput: glyph up to 1 row per cycle (32 cycles minimum); clear takes 9600 cycles.
- Write-port timing: wr_* are synchronous to CLK. The framebuffer RAM write port is clocked by CLK, and the RAM is dual-clock against the scan-out side.

## Configuration
- FBW_CLEAR_EN defined: CLEAR state, fill-address counter and cmd_fill path are present.
- FBW_CLEAR_EN undefined: that logic is removed. A command with cmd_op = 1 is consumed and pulses err, with no writes.

## Test plan
- Reset, then idle: cmd_ready = 1, all other outputs 0. Assert reset mid-glyph after 10 rows: outputs return to reset values immediately, and no further writes occur.
- Glyph at col 0, row 0 with rows 0xFFE0, 0x3FE0, … -> 32 writes at addresses 0, 20, …, 620; wr_be = 2'b10; wr_data = {row,16'h0}; done on the address-620 write.
- Glyph at col 39, row 448 with row_valid toggling every other cycle -> first address 448*20+19 = 8979, last 9599; wr_be = 2'b01; one write per handshake only.
- Invalid commands (col 40; row 449) -> consumed, err pulses once, wr_en stays 0, cmd_ready stays 1.
- Clear with cmd_fill = 0xA5A5A5A5 (FBW_CLEAR_EN defined) -> 9600 consecutive writes, addresses 0..9599, wr_be = 2'b11, done at 9599. The same command without the macro -> err pulse and no writes.
- Back-to-back glyph commands with cmd_valid held high -> the second command is accepted on the edge after the first command's done, with no lost or duplicated rows.

Source files
------------

// File: rtl/fb_glyph_writer.sv
// Write-side engine for the 1-bpp 640x480 framebuffer: glyph cell writes and optional full clear.
// Define FBW_CLEAR_EN to build the CLEAR path (fill-address counter and cmd_fill register).
module fb_glyph_writer #(
  parameter int unsigned WORDS_PER_LINE = 20,
  parameter int unsigned LINES          = 480,
  parameter int unsigned GLYPH_ROWS     = 32,
  parameter int unsigned AW             = 14
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [5:0]    cmd_col,
  input  logic [8:0]    cmd_row,
  input  logic [31:0]   cmd_fill,
  input  logic          row_valid,
  output logic          row_ready,
  input  logic [15:0]   row_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic [1:0]    wr_be,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned RowCntW = $clog2(GLYPH_ROWS);
  localparam logic [AW-1:0] LineStep = AW'(WORDS_PER_LINE);
  localparam logic [5:0]    MaxCol   = 6'(2 * WORDS_PER_LINE - 1);
  localparam logic [8:0]    MaxRow   = 9'(LINES - GLYPH_ROWS);
  localparam logic [RowCntW-1:0] LastRow = RowCntW'(GLYPH_ROWS - 1);

  typedef enum logic [1:0] {StIdle, StGlyph, StClear} state_e;

  state_e state_q, state_d;

  logic [AW-1:0]      addr_q, addr_d;
  logic               lane_q, lane_d;
  logic [RowCntW-1:0] cnt_q, cnt_d;
  logic               wr_en_q, wr_en_d;
  logic [AW-1:0]      wr_addr_q, wr_addr_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic [1:0]         wr_be_q, wr_be_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic cmd_hs, row_hs, glyph_ok, cmd_ok, last_row;
  logic [AW-1:0] glyph_base;

`ifdef FBW_CLEAR_EN
  localparam logic [AW-1:0] LastAddr = AW'(LINES * WORDS_PER_LINE - 1);
  logic [31:0] fill_q, fill_d;
  logic        last_clr;
  assign last_clr = (addr_q == LastAddr);
`else
  logic unused_fill;
  assign unused_fill = ^cmd_fill;
`endif

  assign cmd_hs     = cmd_valid & (state_q == StIdle);
  assign row_hs     = row_valid & (state_q == StGlyph);
  assign glyph_ok   = (cmd_col <= MaxCol) && (cmd_row <= MaxRow);
  assign last_row   = (cnt_q == LastRow);
  // The constant multiply only happens once per command; per-row addresses step by LineStep.
  assign glyph_base = AW'(cmd_row) * LineStep + AW'(cmd_col[5:1]);

`ifdef FBW_CLEAR_EN
  assign cmd_ok = cmd_op | glyph_ok;
`else
  assign cmd_ok = ~cmd_op & glyph_ok;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (cmd_hs && cmd_ok) state_d = cmd_op ? StClear : StGlyph;
      end
      StGlyph: begin
        if (row_hs && last_row) state_d = StIdle;
      end
      StClear: begin
`ifdef FBW_CLEAR_EN
        if (last_clr) state_d = StIdle;
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    row_ready = (state_q == StGlyph);
    busy      = (state_q != StIdle);
    wr_en     = wr_en_q;
    wr_addr   = wr_addr_q;
    wr_data   = wr_data_q;
    wr_be     = wr_be_q;
    done      = done_q;
    err       = err_q;
  end

  always_comb begin
    addr_d    = addr_q;
    lane_d    = lane_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    wr_be_d   = 2'b00;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef FBW_CLEAR_EN
    fill_d    = fill_q;
`endif
    case (state_q)
      StIdle: begin
        if (cmd_hs) begin
          if (!cmd_ok) begin
            err_d = 1'b1;
          end else if (cmd_op) begin
            addr_d = '0;
`ifdef FBW_CLEAR_EN
            fill_d = cmd_fill;
`endif
          end else begin
            addr_d = glyph_base;
            lane_d = cmd_col[0];
            cnt_d  = '0;
          end
        end
      end
      StGlyph: begin
        if (row_hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = lane_q ? {16'h0, row_data} : {row_data, 16'h0};
          wr_be_d   = lane_q ? 2'b01 : 2'b10;
          done_d    = last_row;
          addr_d    = addr_q + LineStep;
          cnt_d     = cnt_q + 1'b1;
        end
      end
`ifdef FBW_CLEAR_EN
      StClear: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = fill_q;
        wr_be_d   = 2'b11;
        done_d    = last_clr;
        addr_d    = addr_q + 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      lane_q    <= 1'b0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= 2'b00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef FBW_CLEAR_EN
      fill_q    <= '0;
`endif
    end else begin
      addr_q    <= addr_d;
      lane_q    <= lane_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef FBW_CLEAR_EN
      fill_q    <= fill_d;
`endif
    end
  end

endmodule

// File: tb/tb_fb_glyph_writer.sv
// Self-checking bench for fb_glyph_writer: directed and randomized glyph/clear/invalid commands.
module tb_fb_glyph_writer;

  localparam int WPL   = 20;
  localparam int LINES = 480;
  localparam int GR    = 32;
  localparam int AW    = 14;

  logic          CLK = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_op;
  logic [5:0]    cmd_col;
  logic [8:0]    cmd_row;
  logic [31:0]   cmd_fill;
  logic          row_valid, row_ready;
  logic [15:0]   row_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [1:0]    wr_be;
  logic          busy, done, err;

  int checks = 0;
  int errors = 0;

  fb_glyph_writer #(
    .WORDS_PER_LINE(WPL),
    .LINES         (LINES),
    .GLYPH_ROWS    (GR),
    .AW            (AW)
  ) dut (
    .CLK      (CLK),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_col  (cmd_col),
    .cmd_row  (cmd_row),
    .cmd_fill (cmd_fill),
    .row_valid(row_valid),
    .row_ready(row_ready),
    .row_data (row_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, ".row_ready"}, 32'(row_ready), 32'd0);
    chk({tag, ".wr_en"},     32'(wr_en),     32'd0);
    chk({tag, ".wr_addr"},   32'(wr_addr),   32'd0);
    chk({tag, ".wr_data"},   wr_data,        32'd0);
    chk({tag, ".wr_be"},     32'(wr_be),     32'd0);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".done"},      32'(done),      32'd0);
    chk({tag, ".err"},       32'(err),       32'd0);
  endtask

  // Drive a command for one edge; hold keeps cmd_valid high afterwards.
  task automatic issue(input bit op, input int col, input int row, input logic [31:0] fill,
                       input bit hold);
    cmd_op    = op;
    cmd_col   = 6'(col);
    cmd_row   = 9'(row);
    cmd_fill  = fill;
    cmd_valid = 1'b1;
    tick();
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic chk_glyph_accept(input string tag);
    chk({tag, ".busy"},      32'(busy),      32'd1);
    chk({tag, ".row_ready"}, 32'(row_ready), 32'd1);
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd0);
  endtask

  // mode 0: row_valid always high, 1: toggles every other cycle, 2: random gaps.
  task automatic glyph_rows(input string tag, input int col, input int row, input int mode,
                            input int n_rows);
    int i = 0;
    int cyc = 0;
    bit rv;
    logic [15:0] d;
    logic [31:0] exp_data;
    while (i < n_rows) begin
      case (mode)
        0:       rv = 1'b1;
        1:       rv = (cyc % 2) == 1;
        default: rv = ($urandom_range(0, 2) != 0) || (cyc > 200);
      endcase
      d         = 16'($urandom);
      row_valid = rv;
      row_data  = d;
      tick();
      cyc++;
      if (rv) begin
        exp_data = (col % 2 == 1) ? {16'h0, d} : {d, 16'h0};
        chk({tag, ".wr_en"},   32'(wr_en),   32'd1);
        chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(row * WPL + col / 2 + i * WPL));
        chk({tag, ".wr_data"}, wr_data,      exp_data);
        chk({tag, ".wr_be"},   32'(wr_be),   (col % 2 == 1) ? 32'd1 : 32'd2);
        chk({tag, ".done"},    32'(done),    32'(i == GR - 1));
        if (i == GR - 1) begin
          chk({tag, ".end_cmd_ready"}, 32'(cmd_ready), 32'd1);
          chk({tag, ".end_busy"},      32'(busy),      32'd0);
        end
        i++;
      end else begin
        chk({tag, ".gap_wr_en"}, 32'(wr_en), 32'd0);
      end
    end
    row_valid = 1'b0;
  endtask

  task automatic invalid_cmd(input string tag, input bit op, input int col, input int row);
    issue(op, col, row, 32'h1234_5678, 1'b0);
    chk({tag, ".err"},       32'(err),       32'd1);
    chk({tag, ".wr_en"},     32'(wr_en),     32'd0);
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    tick();
    chk({tag, ".err_once"},  32'(err),       32'd0);
    chk({tag, ".wr_en2"},    32'(wr_en),     32'd0);
  endtask

  initial begin
    int c, r, c2, r2;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_col   = '0;
    cmd_row   = '0;
    cmd_fill  = '0;
    row_valid = 1'b0;
    row_data  = '0;
    tick();
    chk_reset_outs("reset");
    @(negedge CLK);
    reset = 1'b0;
    tick();
    chk_reset_outs("idle");

    issue(1'b0, 0, 0, 32'h0, 1'b0);
    chk_glyph_accept("g00_acc");
    glyph_rows("g00", 0, 0, 0, GR);

    issue(1'b0, 39, LINES - GR, 32'h0, 1'b0);
    chk_glyph_accept("g39_acc");
    glyph_rows("g39", 39, LINES - GR, 1, GR);

    for (int k = 0; k < 6; k++) begin
      c = $urandom_range(0, 39);
      r = $urandom_range(0, LINES - GR);
      issue(1'b0, c, r, 32'h0, 1'b0);
      chk_glyph_accept("grnd_acc");
      glyph_rows("grnd", c, r, 2, GR);
    end

    invalid_cmd("bad_col", 1'b0, 40, 0);
    invalid_cmd("bad_row", 1'b0, 0, LINES - GR + 1);
    invalid_cmd("bad_rnd", 1'b0, $urandom_range(40, 63), $urandom_range(0, 511));

`ifdef FBW_CLEAR_EN
    issue(1'b1, 0, 0, 32'hA5A5_A5A5, 1'b0);
    chk("clr_acc.busy", 32'(busy), 32'd1);
    chk("clr_acc.wr_en", 32'(wr_en), 32'd0);
    for (int j = 0; j < LINES * WPL; j++) begin
      tick();
      chk("clr.wr_en",   32'(wr_en),   32'd1);
      chk("clr.wr_addr", 32'(wr_addr), 32'(j));
      chk("clr.wr_data", wr_data,      32'hA5A5_A5A5);
      chk("clr.wr_be",   32'(wr_be),   32'd3);
      chk("clr.done",    32'(done),    32'(j == LINES * WPL - 1));
    end
    chk("clr_end.cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("clr_after.wr_en", 32'(wr_en), 32'd0);
`else
    invalid_cmd("clr_off", 1'b1, 0, 0);
`endif

    // Back-to-back: cmd_valid stays high across the first command's done.
    c  = $urandom_range(0, 39);
    r  = $urandom_range(0, LINES - GR);
    c2 = $urandom_range(0, 39);
    r2 = $urandom_range(0, LINES - GR);
    issue(1'b0, c, r, 32'h0, 1'b1);
    chk_glyph_accept("b2b1_acc");
    glyph_rows("b2b1", c, r, 0, GR);
    issue(1'b0, c2, r2, 32'h0, 1'b0);
    chk_glyph_accept("b2b2_acc");
    glyph_rows("b2b2", c2, r2, 2, GR);
    tick();
    chk("b2b_after.wr_en",     32'(wr_en),     32'd0);
    chk("b2b_after.cmd_ready", 32'(cmd_ready), 32'd1);

    // Reset after 10 rows aborts the glyph.
    issue(1'b0, 5, 100, 32'h0, 1'b0);
    chk_glyph_accept("rst_acc");
    glyph_rows("rst_rows", 5, 100, 0, 10);
    row_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outs("rst_mid");
    tick();
    chk_reset_outs("rst_hold");
    @(negedge CLK);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_post.wr_en",     32'(wr_en),     32'd0);
      chk("rst_post.row_ready", 32'(row_ready), 32'd0);
      chk("rst_post.cmd_ready", 32'(cmd_ready), 32'd1);
    end
    row_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
